// File: rtl/scan_sel.sv
// scan_sel: sweeps a 3-bit decoder select from first to last, holding each index dwell+1 cycles
// Ports: clk/rst (sync, active-high); start/stop request and abort a sweep; first/last/dwell
// are latched at start; loop (live) restarts the sweep at last; sel drives the decoder;
// active marks RUN; step pulses when sel changes inside a sweep; done pulses on normal completion.
// Optional macro SCAN_DOWN_EN adds input down (latched at start) to sweep decrementing.
module scan_sel #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         first,
  input  logic [2:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
`ifdef SCAN_DOWN_EN
  input  logic               down,
`endif
  output logic [2:0]         sel,
  output logic               active,
  output logic               step,
  output logic               done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t               r_state;
  logic [2:0]           r_sel, r_first, r_last;
  logic [DWELL_W-1:0]   r_dwell, r_cnt;
  logic                 r_active, r_step, r_done;
  logic [2:0]           w_next;
`ifdef SCAN_DOWN_EN
  logic                 r_down;
  assign w_next = r_down ? r_sel - 3'd1 : r_sel + 3'd1;
`else
  assign w_next = r_sel + 3'd1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_first  <= '0;
      r_last   <= '0;
      r_dwell  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_step   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SCAN_DOWN_EN
      r_down   <= 1'b0;
`endif
    end else begin
      r_step <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start && !stop) begin
          r_state  <= RUN;
          r_active <= 1'b1;
          r_sel    <= first;
          r_first  <= first;
          r_last   <= last;
          r_dwell  <= dwell;
          r_cnt    <= '0;
`ifdef SCAN_DOWN_EN
          r_down   <= down;
`endif
        end
        RUN: if (stop) begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end else if (r_cnt == r_dwell) begin
          r_cnt <= '0;
          if (r_sel != r_last) begin
            r_sel  <= w_next;
            r_step <= 1'b1;
          end else if (loop) begin
            r_sel  <= r_first;
            r_step <= 1'b1;
          end else begin
            r_state  <= IDLE;
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + DWELL_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign sel    = r_sel;
  assign active = r_active;
  assign step   = r_step;
  assign done   = r_done;
endmodule

// File: tb/tb_scan_sel.sv
// tb_scan_sel: randomized scoreboard bench for scan_sel against an expanded-sequence model
module tb_scan_sel;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [2:0] first = '0, last = '0;
  logic [DW-1:0] dwell = '0;
  logic down = 1'b0;
  logic [2:0] sel;
  logic active, step, done;
  always #5 clk = ~clk;
  scan_sel #(.DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .first(first), .last(last), .dwell(dwell), .loop(loop),
`ifdef SCAN_DOWN_EN
    .down(down),
`endif
    .sel(sel), .active(active), .step(step), .done(done)
  );
  typedef struct packed {
    logic [2:0] sel;
    logic active;
    logic step;
    logic done;
  } obs_t;
  obs_t q[$];
  obs_t e_m;
  int total = 0, bad = 0;
  bit m_run = 0;
  logic [2:0] m_sel = '0;
  logic [2:0] seq[$];
  int p = 0, hold = 1;
  bit down_ok;
`ifdef SCAN_DOWN_EN
  initial down_ok = 1;
`else
  initial down_ok = 0;
`endif
  task automatic drive(input bit r, input bit s, input bit sp, input logic [2:0] f,
                       input logic [2:0] l, input int d, input bit lp, input bit dn);
    obs_t e;
    logic [2:0] i;
    bit dd;
    @(negedge clk);
    dd = dn && down_ok;
    rst = r; start = s; stop = sp; first = f; last = l; dwell = DW'(d); loop = lp; down = dn;
    e.step = 0;
    e.done = 0;
    if (r) begin
      m_run = 0;
      m_sel = 0;
    end else if (!m_run) begin
      if (s && !sp) begin
        seq.delete();
        i = f;
        forever begin
          repeat (d + 1) seq.push_back(i);
          if (i == l) break;
          i = dd ? i - 3'd1 : i + 3'd1;
        end
        p = 0;
        hold = d + 1;
        m_run = 1;
        m_sel = seq[0];
      end
    end else if (sp) begin
      m_run = 0;
    end else begin
      p++;
      if (p == seq.size()) begin
        if (lp) begin
          p = 0;
          e.step = 1;
          m_sel = seq[0];
        end else begin
          m_run = 0;
          e.done = 1;
        end
      end else begin
        e.step = (p % hold == 0);
        m_sel = seq[p];
      end
    end
    e.sel = m_sel;
    e.active = m_run;
    q.push_back(e);
  endtask
  task automatic idle(input int n, input bit lp);
    for (int k = 0; k < n; k++)
      drive(0, 0, 0, 3'($urandom), 3'($urandom), int'($urandom_range(0, 5)), lp, 1'($urandom));
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e_m = q.pop_front();
      total++;
      if ({sel, active, step, done} !== e_m) begin
        bad++;
        $display("FAIL cycle_out t=%0t sel/active/step/done got %0d/%b/%b/%b exp %0d/%b/%b/%b",
                 $time, sel, active, step, done, e_m.sel, e_m.active, e_m.step, e_m.done);
      end
    end
  end
  initial begin
    bit lp;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 5, 6, 3, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 2, 5, 1, 0, 0);
    idle(10, 0);
    drive(0, 1, 0, 6, 1, 0, 0, 0);
    idle(6, 0);
    drive(0, 1, 0, 0, 1, 0, 1, 0);
    idle(5, 1);
    drive(0, 0, 1, 0, 1, 0, 1, 0);
    idle(4, 1);
    drive(0, 1, 0, 3, 3, 4, 0, 0);
    idle(8, 0);
    drive(0, 1, 1, 2, 4, 0, 0, 0);
    idle(2, 0);
    drive(0, 1, 0, 2, 6, 3, 0, 0);
    idle(9, 0);
    drive(1, 1, 1, 2, 6, 3, 0, 0);
    drive(0, 1, 0, 1, 3, 1, 0, 0);
    idle(8, 0);
    drive(0, 1, 0, 1, 6, 0, 0, 1);
    idle(6, 0);
    lp = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) lp = ~lp;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0,
            3'($urandom), 3'($urandom), int'($urandom_range(0, 5)), lp, 1'($urandom));
    end
    idle(3, 0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scan_sel.md
SCAN_SEL -- requirements
Module: scan_sel

Interface
REQ-001 Parameter DWELL_W, default 8, sets the width of the dwell count.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port start, input, 1: request a sweep; sampled only in IDLE.
REQ-005 Port stop, input, 1: abort the running sweep.
REQ-006 Port first, input, 3: first select index of the sweep; latched at start.
REQ-007 Port last, input, 3: final select index of the sweep; latched at start.
REQ-008 Port dwell, input, DWELL_W: extra hold cycles per index; latched at start.
REQ-009 Port loop, input, 1: 1 = continuous sweep; sampled live each cycle.
REQ-010 Port sel, output, 3: current index, drives the downstream 3-to-8 decoder input.
REQ-011 Port active, output, 1: high while in RUN.
REQ-012 Port step, output, 1: one-cycle pulse in the cycle sel takes a new value inside a sweep.
REQ-013 Port done, output, 1: one-cycle pulse on normal sweep completion.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN; active is registered and equals (state==RUN).
REQ-015 In IDLE with start=1 and stop=0, next cycle: state RUN, sel=first, dwell counter=0, active=1, step=0.
REQ-016 In IDLE, start=1 with stop=1 SHALL be ignored (stop wins); state stays IDLE.
REQ-017 In RUN, start SHALL be ignored.
REQ-018 Each index SHALL be held exactly dwell+1 cycles; dwell=0 advances every cycle.
REQ-019 The dwell counter SHALL count 0..dwell and clear to 0 on every index change.
REQ-020 On hold expiry with sel!=last: sel advances by one modulo 8 (7 wraps to 0), step=1 that cycle.
REQ-021 On hold expiry with sel==last and loop=1: sel=first, step=1, remain RUN, done=0.
REQ-022 On hold expiry with sel==last and loop=0: state IDLE, active=0, done=1 for one cycle, sel holds last.
REQ-023 first>last SHALL sweep through the wrap (e.g. 6,7,0,1); first==last SHALL give one index for dwell+1 cycles.
REQ-024 stop=1 in RUN SHALL, next cycle, enter IDLE with active=0, done=0, step=0, sel holding its current value; stop beats a coincident hold expiry.
REQ-025 stop in IDLE SHALL have no effect.
REQ-026 done and step SHALL never assert outside the cycles defined above and never together.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, sel=0, counter=0, active=0, step=0, done=0, latched first/last/dwell=0.
REQ-028 rst SHALL override start, stop and any in-progress sweep, including mid-hold; no done is produced.

Configuration
REQ-029 Macro SCAN_DOWN_EN: when defined, a 1-bit input port down exists, latched at start; down=1 makes every advance decrement sel modulo 8 (0 wraps to 7), all other rules unchanged.
REQ-030 Without SCAN_DOWN_EN the down port SHALL be absent and sweeps always increment.

Verification
REQ-031 Basic: first=2,last=5,dwell=1,loop=0, start at cycle N -> sel 2@N+1..N+2, 3@N+3..4, 4@N+5..6, 5@N+7..8; step at N+3,N+5,N+7; done and active=0 at N+9.
REQ-032 Wrap: first=6,last=1,dwell=0 -> sel 6,7,0,1 on N+1..N+4, done at N+5.
REQ-033 Loop/stop: first=0,last=1,dwell=0,loop=1 -> sel 0,1,0,1...; stop at N+6 -> active=0 at N+7, done never asserts, sel frozen.
REQ-034 Edge cases: first=last=3,dwell=4 -> sel=3 for 5 cycles, no step, done at N+6; start with stop same cycle -> stays IDLE.
REQ-035 Reset mid-sweep: rst during dwell of index 4 -> next cycle sel=0, active=0, done=0; a following start runs a clean sweep.
REQ-036 With SCAN_DOWN_EN: first=1,last=6,dwell=0,down=1 -> sel 1,0,7,6, done at N+5.
